atconv_sched: RTL and testbench
===============================

// Module: atconv_sched
// PURPOSE
//  Control sequencer for the ATCONV datapath: 3x3 atrous conv (dilation DIL) with
//  replicate padding on a 64x64 13-bit image, then 2x2 max-pool. Owns the ready/busy
//  handshake and drives image and layer-memory addresses. Emits MAC/pool strobes; never
//  touches pixel data. Sits between the host interface and the MAC/ReLU/pool datapath.
// PARAMETERS
//  IMG_W   64  image width and height in pixels (power of 2)
//  ADDR_W  12  address width, log2(IMG_W*IMG_W)
//  DIL      2  dilation; tap offsets are {-DIL,0,+DIL} in both axes
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       async, active-low (0 = reset)
//  ready     in   1       host start request; sampled only in IDLE
//  busy      out  1       high from start until the last layer-1 write completes
//  iaddr     out  ADDR_W  image address; idata is valid at the next rising edge
//  tap_idx   out  4       kernel tap (0..8) matching the idata currently sampled
//  mac_clr   out  1       clear accumulator (first cycle of each pixel)
//  mac_en    out  1       accumulate idata*w[tap_idx]
//  pool_clr  out  1       clear max register
//  pool_en   out  1       max-update with cdata_rd
//  cwr       out  1       layer-memory write strobe
//  crd       out  1       layer-memory read strobe; cdata_rd is valid at the next rising edge
//  csel      out  1       0 = layer 0 (ReLU map, 4096 words), 1 = layer 1 (pool, 1024 words)
//  caddr_wr  out  ADDR_W  write address
//  caddr_rd  out  ADDR_W  read address
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE. All outputs 0, including busy, csel and addresses.
//  IDLE: ready==1 -> CONV with pixel p=0, and busy=1 from the next cycle.
//   ready is ignored outside IDLE.
//  CONV: 11 cycles per pixel p=(y,x), counter c=0..10.
//   c0..8: iaddr = clamp(y+dy)*IMG_W + clamp(x+dx), tap t=c row-major.
//    dy,dx are in {-DIL,0,+DIL}; clamp limits to [0,IMG_W-1].
//   c1..9: mac_en=1, tap_idx=c-1. mac_clr=1 at c0 only.
//   c10: cwr=1, csel=0, caddr_wr=p.
//   p=4095 at c10 -> POOL with o=0; otherwise p+1.
//  POOL: 6 cycles per output o, with oy=o/(IMG_W/2), ox=o%(IMG_W/2), counter c=0..5.
//   c0..3: crd=1, csel=0, caddr_rd in order (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
//   c1..4: pool_en=1. pool_clr=1 at c0.
//   c5: cwr=1, csel=1, caddr_wr=o.
//   o=1023 at c5 -> DONE.
//  DONE: busy=0 for one cycle -> IDLE.
//  Total run length: 4096*11 + 1024*6 + 1 = 51201 cycles from start to busy falling.
//  cwr and crd are never high together. csel is 0 whenever crd=1.
//  Outside their active cycles, strobes are 0 and addresses hold their last value.
//  Pixel counter is ADDR_W bits and wraps only via the state transition; no free-run wrap.
//  Reset mid-run aborts at once: no partial write completes after reset falls.
// STRUCTURE
//  atconv_pkg: state enum {IDLE,CONV,POOL,DONE}, IMG_W, DIL, tap offset tables dy[9] and dx[9].
//  Sub-module atconv_tap_addr: combinational (y,x,tap) -> clamped iaddr.
//  Top: FSM, pixel/output counters, phase counter, registered outputs.
// TESTING
//  1. Start: reset low 3 cycles, ready=1 -> busy=1 one cycle later.
//     Drop ready; busy falls exactly 51201 cycles after start.
//  2. Corner pixel p=0: iaddr sequence 0,0,2,0,0,2,128,128,130. cwr at c10 with caddr_wr=0.
//  3. Pixel p=4095: iaddr sequence 3965,3967,3967,4093,4095,4095,4093,4095,4095.
//  4. Pool o=33: caddr_rd sequence 130,131,194,195, then cwr csel=1 caddr_wr=33.
//  5. Reset pulled low mid-CONV at p=100 -> all outputs 0 immediately.
//     After release, ready restarts from p=0.
//  6. Full run with golden datapath model: layer 0 and layer 1 match golden data.
//     cwr&crd never both high; ready pulses while busy=1 are ignored.

Source files
------------

// File: rtl/atconv_pkg.sv
// Shared types and constants for the ATCONV control sequencer: FSM states,
// image geometry, per-pixel phase boundaries and the 3x3 tap offset tables.
package atconv_pkg;

    localparam int IMG_W   = 64;
    localparam int ADDR_W  = 12;
    localparam int DIL     = 2;
    localparam int COORD_W = ADDR_W / 2;
    localparam int HALF_W  = COORD_W - 1;
    localparam int OUT_W   = ADDR_W - 2;

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_W - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST = OUT_W'(IMG_W * IMG_W / 4 - 1);

    localparam logic [3:0] TAP_LAST     = 4'd8;
    localparam logic [3:0] MAC_LAST     = 4'd9;
    localparam logic [3:0] CONV_LAST    = 4'd10;
    localparam logic [3:0] POOL_RD_LAST = 4'd3;
    localparam logic [3:0] POOL_EN_LAST = 4'd4;
    localparam logic [3:0] POOL_LAST    = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        POOL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OFF_NEG,
        OFF_ZERO,
        OFF_POS
    } off_t;

    // Taps are numbered row-major over the 3x3 kernel.
    function automatic off_t tap_dy(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: return OFF_NEG;
            4'd3, 4'd4, 4'd5: return OFF_ZERO;
            default:          return OFF_POS;
        endcase
    endfunction

    function automatic off_t tap_dx(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: return OFF_NEG;
            4'd1, 4'd4, 4'd7: return OFF_ZERO;
            default:          return OFF_POS;
        endcase
    endfunction

endpackage

// File: rtl/atconv_tap_addr.sv
// Combinational image address for one kernel tap of pixel (y,x), with the
// dilated coordinates clamped to the image edge (replicate padding).
module atconv_tap_addr
    import atconv_pkg::*;
(
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x,
    input  logic [3:0]         tap,
    output logic [ADDR_W-1:0]  iaddr
);

    localparam logic signed [COORD_W+1:0] DIL_S = (COORD_W + 2)'(DIL);
    localparam logic signed [COORD_W+1:0] MAX_S = (COORD_W + 2)'(IMG_W - 1);

    // Two guard bits hold both the negative and the past-the-edge excursions.
    function automatic logic [COORD_W-1:0] shift_clamp(input logic [COORD_W-1:0] c,
                                                       input off_t off);
        logic signed [COORD_W+1:0] s;
        s = $signed({2'b00, c});
        if (off == OFF_NEG) begin
            s = s - DIL_S;
        end else if (off == OFF_POS) begin
            s = s + DIL_S;
        end
        if (s[COORD_W+1]) begin
            return '0;
        end
        if (s > MAX_S) begin
            return MAX_S[COORD_W-1:0];
        end
        return s[COORD_W-1:0];
    endfunction

    assign iaddr = {shift_clamp(y, tap_dy(tap)), shift_clamp(x, tap_dx(tap))};

endmodule

// File: rtl/atconv_sched.sv
// ATCONV control sequencer: walks every pixel through 11 conv cycles, then every
// 2x2 block through 6 pool cycles, driving memory addresses and datapath strobes.
module atconv_sched
    import atconv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic [3:0]        tap_idx,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              pool_clr,
    output logic              pool_en,
    output logic              cwr,
    output logic              crd,
    output logic              csel,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd
);

    state_t              state_q, state_d;
    logic [3:0]          phase_q, phase_d;
    logic [ADDR_W-1:0]   pix_q, pix_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [ADDR_W-1:0]   tap_addr;

    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
    logic [3:0]          tap_idx_q, tap_idx_d;
    logic                mac_clr_q, mac_clr_d;
    logic                mac_en_q, mac_en_d;
    logic                pool_clr_q, pool_clr_d;
    logic                pool_en_q, pool_en_d;
    logic                cwr_q, cwr_d;
    logic                crd_q, crd_d;
    logic                csel_q, csel_d;
    logic [ADDR_W-1:0]   caddr_wr_q, caddr_wr_d;
    logic [ADDR_W-1:0]   caddr_rd_q, caddr_rd_d;

    // Address of the tap that the next cycle presents, so iaddr can be registered.
    atconv_tap_addr u_tap_addr (
        .y     (pix_d[ADDR_W-1:COORD_W]),
        .x     (pix_d[COORD_W-1:0]),
        .tap   (phase_d),
        .iaddr (tap_addr)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pix_d   = pix_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = CONV;
                    phase_d = '0;
                    pix_d   = '0;
                end
            end
            CONV: begin
                if (phase_q == CONV_LAST) begin
                    phase_d = '0;
                    if (pix_q == PIX_LAST) begin
                        state_d = POOL;
                        out_d   = '0;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            POOL: begin
                if (phase_q == POOL_LAST) begin
                    phase_d = '0;
                    if (out_q == OUT_LAST) begin
                        state_d = DONE;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it;
    // addresses, tap index and csel keep their last value outside active cycles.
    always_comb begin
        busy_d     = (state_d == CONV) || (state_d == POOL);
        iaddr_d    = iaddr_q;
        tap_idx_d  = tap_idx_q;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        pool_clr_d = 1'b0;
        pool_en_d  = 1'b0;
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        case (state_d)
            CONV: begin
                mac_clr_d = (phase_d == 4'd0);
                if (phase_d <= TAP_LAST) begin
                    iaddr_d = tap_addr;
                end
                if ((phase_d != 4'd0) && (phase_d <= MAC_LAST)) begin
                    mac_en_d  = 1'b1;
                    tap_idx_d = phase_d - 4'd1;
                end
                if (phase_d == CONV_LAST) begin
                    cwr_d      = 1'b1;
                    csel_d     = 1'b0;
                    caddr_wr_d = pix_d;
                end
            end
            POOL: begin
                pool_clr_d = (phase_d == 4'd0);
                pool_en_d  = (phase_d != 4'd0) && (phase_d <= POOL_EN_LAST);
                if (phase_d <= POOL_RD_LAST) begin
                    crd_d      = 1'b1;
                    csel_d     = 1'b0;
                    caddr_rd_d = {out_d[OUT_W-1:HALF_W], phase_d[1],
                                  out_d[HALF_W-1:0], phase_d[0]};
                end
                if (phase_d == POOL_LAST) begin
                    cwr_d      = 1'b1;
                    csel_d     = 1'b1;
                    caddr_wr_d = {{(ADDR_W - OUT_W){1'b0}}, out_d};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            pix_q      <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            iaddr_q    <= '0;
            tap_idx_q  <= '0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            pool_clr_q <= 1'b0;
            pool_en_q  <= 1'b0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pix_q      <= pix_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            iaddr_q    <= iaddr_d;
            tap_idx_q  <= tap_idx_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            pool_clr_q <= pool_clr_d;
            pool_en_q  <= pool_en_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
        end
    end

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign tap_idx  = tap_idx_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign pool_clr = pool_clr_q;
    assign pool_en  = pool_en_q;
    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;

endmodule

// File: tb/tb_atconv_sched.sv
// Bench for atconv_sched: cycle-index model of every output, a golden conv/pool
// datapath around the sequencer, and hand-computed address sequences.
module tb_atconv_sched;

    localparam int DILT     = 2;
    localparam int CONV_CYC = 4096 * 11;
    localparam int RUN_CYC  = CONV_CYC + 1024 * 6;
    localparam int WGT [9]         = '{1, -2, 3, -1, 4, -1, 2, -3, 1};
    localparam int EXP_P0 [9]      = '{0, 0, 2, 0, 0, 2, 128, 128, 130};
    localparam int EXP_P4095 [9]   = '{3965, 3967, 3967, 4093, 4095, 4095, 4093, 4095, 4095};
    localparam int EXP_O33_RD [4]  = '{130, 131, 194, 195};

    typedef struct packed {
        logic        busy;
        logic [11:0] iaddr;
        logic [3:0]  tap_idx;
        logic        mac_clr;
        logic        mac_en;
        logic        pool_clr;
        logic        pool_en;
        logic        cwr;
        logic        crd;
        logic        csel;
        logic [11:0] caddr_wr;
        logic [11:0] caddr_rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready = 1'b0;
    logic        busy;
    logic [11:0] iaddr;
    logic [3:0]  tap_idx;
    logic        mac_clr, mac_en, pool_clr, pool_en, cwr, crd, csel;
    logic [11:0] caddr_wr, caddr_rd;

    obs_t obs;
    obs_t m_exp;
    int   m_mode, m_k;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    int img [4096];
    int layer0 [4096] = '{default: -1};
    int layer1 [1024] = '{default: -1};
    int gold0 [4096];
    int idata_q, cdata_q, acc, maxv;

    atconv_sched dut (
        .clk      (clk),
        .reset    (reset_n),
        .ready    (ready),
        .busy     (busy),
        .iaddr    (iaddr),
        .tap_idx  (tap_idx),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .pool_clr (pool_clr),
        .pool_en  (pool_en),
        .cwr      (cwr),
        .crd      (crd),
        .csel     (csel),
        .caddr_wr (caddr_wr),
        .caddr_rd (caddr_rd)
    );

    always #5 clk = ~clk;

    assign obs = {busy, iaddr, tap_idx, mac_clr, mac_en, pool_clr, pool_en,
                  cwr, crd, csel, caddr_wr, caddr_rd};

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > 63) return 63;
        return v;
    endfunction

    // Model mode: 0 idle, 1 running (k = cycles since the first busy cycle), 2 done.
    function automatic int next_mode(input int mode, input int k, input logic rdy);
        if (mode == 0) return rdy ? 1 : 0;
        if (mode == 1) return (k == RUN_CYC - 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic int next_k(input int mode, input int k);
        if (mode == 1) return (k == RUN_CYC - 1) ? k : k + 1;
        return 0;
    endfunction

    function automatic obs_t predict(input int mode, input int k, input obs_t prev);
        obs_t e;
        int p, c, y, x, o;
        e = prev;
        e.busy     = (mode == 1);
        e.mac_clr  = 1'b0;
        e.mac_en   = 1'b0;
        e.pool_clr = 1'b0;
        e.pool_en  = 1'b0;
        e.cwr      = 1'b0;
        e.crd      = 1'b0;
        if (mode == 1 && k < CONV_CYC) begin
            p = k / 11;
            c = k % 11;
            y = p / 64;
            x = p % 64;
            e.mac_clr = (c == 0);
            if (c <= 8)
                e.iaddr = 12'(clampc(y + (c / 3 - 1) * DILT) * 64 + clampc(x + (c % 3 - 1) * DILT));
            if (c >= 1 && c <= 9) begin
                e.mac_en  = 1'b1;
                e.tap_idx = 4'(c - 1);
            end
            if (c == 10) begin
                e.cwr      = 1'b1;
                e.csel     = 1'b0;
                e.caddr_wr = 12'(p);
            end
        end else if (mode == 1) begin
            o = (k - CONV_CYC) / 6;
            c = (k - CONV_CYC) % 6;
            if (c <= 3) begin
                e.crd      = 1'b1;
                e.csel     = 1'b0;
                e.caddr_rd = 12'((2 * (o / 32) + c / 2) * 64 + 2 * (o % 32) + c % 2);
            end
            e.pool_clr = (c == 0);
            e.pool_en  = (c >= 1 && c <= 4);
            if (c == 5) begin
                e.cwr      = 1'b1;
                e.csel     = 1'b1;
                e.caddr_wr = 12'(o);
            end
        end
        return e;
    endfunction

    function automatic int golden_conv(input int p);
        int s, y, x;
        s = 0;
        y = p / 64;
        x = p % 64;
        for (int t = 0; t < 9; t++)
            s += img[clampc(y + (t / 3 - 1) * DILT) * 64 + clampc(x + (t % 3 - 1) * DILT)] * WGT[t];
        return (s > 0) ? s : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0;
            m_k    <= 0;
            m_exp  <= '0;
        end else begin
            m_mode <= next_mode(m_mode, m_k, ready);
            m_k    <= next_k(m_mode, m_k);
            m_exp  <= predict(next_mode(m_mode, m_k, ready), next_k(m_mode, m_k), m_exp);
        end
    end

    // Golden datapath driven only by the sequencer's strobes and addresses.
    always @(posedge clk) begin
        idata_q <= img[iaddr];
        if (crd) cdata_q <= layer0[caddr_rd];
        if (mac_clr) acc <= 0;
        else if (mac_en) acc <= acc + idata_q * WGT[tap_idx];
        if (pool_clr) maxv <= 0;
        else if (pool_en && cdata_q > maxv) maxv <= cdata_q;
        if (cwr && !csel) layer0[caddr_wr] <= (acc > 0) ? acc : 0;
        if (cwr && csel) layer1[caddr_wr[9:0]] <= maxv;
    end

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check_obs("cycle_model", obs, m_exp);
        if (cwr || crd)
            check_val("strobe_excl", int'(cwr & crd) + int'(crd & csel), 0);
    end

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic apply_start();
        ready = 1'b1;
        check_val("busy_before_start", int'(busy), 0);
        @(negedge clk);
        ready = 1'b0;
        cyc = 1;
        check_val("busy_after_start", int'(busy), 1);
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        step_to(cyc + 1);
        ready = 1'b0;
    endtask

    initial begin
        int mism, first, base, g, m, oy, ox;
        for (int a = 0; a < 4096; a++)
            img[a] = ((a * 73) ^ (a >> 3)) & 13'h1fff;

        repeat (3) @(negedge clk);
        check_obs("reset_state", obs, '0);
        reset_n = 1'b1;
        @(negedge clk);

        apply_start();
        check_val("p0_mac_clr", int'(mac_clr), 1);
        for (int c = 0; c <= 8; c++) begin
            step_to(1 + c);
            check_val($sformatf("p0_iaddr_c%0d", c), int'(iaddr), EXP_P0[c]);
        end
        step_to(11);
        check_val("p0_cwr", int'(cwr), 1);
        check_val("p0_caddr_wr", int'(caddr_wr), 0);

        step_to(500);
        pulse_ready();

        base = 1 + 4095 * 11;
        for (int c = 0; c <= 8; c++) begin
            step_to(base + c);
            check_val($sformatf("p4095_iaddr_c%0d", c), int'(iaddr), EXP_P4095[c]);
        end

        base = 1 + CONV_CYC + 33 * 6;
        for (int c = 0; c <= 3; c++) begin
            step_to(base + c);
            check_val($sformatf("o33_crd_c%0d", c), int'(crd), 1);
            check_val($sformatf("o33_caddr_rd_c%0d", c), int'(caddr_rd), EXP_O33_RD[c]);
        end
        step_to(base + 5);
        check_val("o33_cwr", int'(cwr), 1);
        check_val("o33_csel", int'(csel), 1);
        check_val("o33_caddr_wr", int'(caddr_wr), 33);
        pulse_ready();

        while (busy && cyc < RUN_CYC + 100)
            step_to(cyc + 1);
        check_val("busy_fall_cycle", cyc, 51201);
        step_to(cyc + 3);

        mism = 0;
        first = -1;
        for (int p = 0; p < 4096; p++) begin
            g = golden_conv(p);
            gold0[p] = g;
            if (layer0[p] != g) begin
                mism++;
                if (first < 0) first = p;
            end
        end
        check_val("layer0_mismatches", mism, 0);
        if (first >= 0) check_val("layer0_first_bad", layer0[first], gold0[first]);

        mism = 0;
        first = -1;
        for (int o = 0; o < 1024; o++) begin
            oy = o / 32;
            ox = o % 32;
            m = 0;
            for (int d = 0; d < 4; d++)
                if (gold0[(2 * oy + d / 2) * 64 + 2 * ox + d % 2] > m)
                    m = gold0[(2 * oy + d / 2) * 64 + 2 * ox + d % 2];
            if (layer1[o] != m) begin
                mism++;
                if (first < 0) first = o;
            end
        end
        check_val("layer1_mismatches", mism, 0);

        apply_start();
        step_to(1 + 100 * 11 + 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_obs("reset_abort", obs, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        apply_start();
        check_val("restart_mac_clr", int'(mac_clr), 1);
        for (int c = 0; c <= 2; c++) begin
            step_to(1 + c);
            check_val($sformatf("restart_iaddr_c%0d", c), int'(iaddr), EXP_P0[c]);
        end
        step_to(11);
        check_val("restart_cwr", int'(cwr), 1);
        check_val("restart_caddr_wr", int'(caddr_wr), 0);
        step_to(15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
